uart_loop_buffer: RTL and testbench
===================================

// Module: uart_loop_buffer
// PURPOSE
//   Elastic byte buffer between uart_rx and uart_tx in the loopback path.
//   Captures every uart_rx_done/uart_rx_data strobe into a FIFO.
//   Drains the FIFO into uart_tx one byte at a time, honouring uart_tx_busy.
//   Back-to-back received bytes are no longer lost while the transmitter is busy.
// PARAMETERS
//   DATA_W    8   byte width
//   ADDR_W    4   FIFO address width; DEPTH = 2**ADDR_W (16 entries)
//   BUSY_TMO  4   cycles to wait for tx_busy to rise after a tx_en pulse
// PORTS
//   clk       in   1         system clock
//   rst       in   1         asynchronous reset, active-high
//   rx_done   in   1         1-cycle strobe: rx_data valid (from uart_rx)
//   rx_data   in   DATA_W    received byte
//   tx_busy   in   1         uart_tx busy flag
//   tx_en     out  1         1-cycle start strobe to uart_tx
//   tx_data   out  DATA_W    byte to uart_tx; held stable from tx_en until back in IDLE
//   fifo_cnt  out  ADDR_W+1  current occupancy, 0..DEPTH
//   ovf       out  1         sticky: a byte was dropped because the FIFO was full
//   ovf_clr   in   1         synchronous clear of ovf
// BEHAVIOUR
// - Reset (rst=1, async): tx_en=0, tx_data=0, fifo_cnt=0, ovf=0, pointers=0, state=IDLE.
//   FIFO memory contents are don't-care.
// - Push: rx_done=1 and not full -> mem[wr_ptr]<=rx_data, wr_ptr++.
//   rx_done=1 and full -> byte dropped, ovf<=1.
// - ovf_clr=1 clears ovf. If it coincides with a drop, set wins.
// - Pointers wrap modulo DEPTH. full = (fifo_cnt==DEPTH); empty = (fifo_cnt==0).
// - Push and pop in the same cycle -> fifo_cnt unchanged.
//   When full, a simultaneous pop frees a slot, so the push is accepted and ovf is not set.
// - FSM:
//   IDLE       if !empty && !tx_busy: tx_data<=mem[rd_ptr], rd_ptr++ (pop), tx_en<=1 -> SEND
//   SEND       tx_en<=0, tmo<=0 -> WAIT_BUSY (tx_en is high exactly 1 cycle)
//   WAIT_BUSY  tx_busy=1 -> WAIT_DONE
//              else if tmo==BUSY_TMO-1 -> IDLE
//              else tmo++
//   WAIT_DONE  tx_busy=0 -> IDLE
// - Latency, empty FIFO and idle tx: rx_done sampled at edge N -> fifo_cnt=1 after N ->
//   pop at edge N+1 -> tx_en=1 and tx_data valid during cycle N+1..N+2 (2-edge latency).
// - Bytes leave in arrival order. No byte is sent twice. Exactly one tx_en per popped byte.
// - rst mid-transfer: FSM and FIFO are discarded immediately. tx_en=0 on the next cycle.
//   Buffered bytes are lost; uart_tx finishes or aborts on its own reset.
// - fifo_cnt is registered and updated at the same edge as the pointers.
// TESTING
// 1 Single byte: rx_done with 0xA5, tx model busy 10 cycles
//   -> one tx_en pulse 2 edges later, tx_data=0xA5, fifo_cnt 0->1->0.
// 2 Burst: 5 strobes 0x01..0x05 on consecutive cycles, busy 20 cycles per byte
//   -> 5 tx_en pulses, data 01,02,03,04,05 in order, peak fifo_cnt=4 or 5, ovf=0.
// 3 Overflow: tx_busy forced 1, push 18 bytes
//   -> fifo_cnt=16, ovf=1. Release busy: 16 bytes out, the 17th and 18th never appear.
//   Then pulse ovf_clr -> ovf=0.
// 4 Timeout: tx_busy never rises, push 0x3C then 0xC3
//   -> tx_en for 0x3C, IDLE after BUSY_TMO cycles, then tx_en for 0xC3.
// 5 Full plus simultaneous: fill to 16, pop and push the same cycle
//   -> fifo_cnt stays 16, ovf stays 0, new byte emitted last.
// 6 Reset mid-op: assert rst during WAIT_DONE with 3 bytes queued
//   -> immediate tx_en=0, fifo_cnt=0, ovf=0. The next pushed byte is sent normally.

Source files
------------

// File: rtl/uart_loop_buffer.sv
// Elastic byte FIFO between uart_rx and uart_tx in the loopback path.
// Every rx strobe is queued; bytes drain one at a time as uart_tx becomes free.
module uart_loop_buffer #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int BUSY_TMO = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_done,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              tx_busy,
  output logic              tx_en,
  output logic [DATA_W-1:0] tx_data,
  output logic [ADDR_W:0]   fifo_cnt,
  output logic              ovf,
  input  logic              ovf_clr
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int TMO_W = $clog2(BUSY_TMO + 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                tx_en_q, tx_en_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic full, empty, pop, push, drop;

  assign full  = (cnt_q == (ADDR_W+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign pop   = (state_q == IDLE) && !empty && !tx_busy;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push  = rx_done && (!full || pop);
  assign drop  = rx_done && full && !pop;

  always_comb begin
    state_d   = state_q;
    tx_en_d   = 1'b0;
    tx_data_d = tx_data_q;
    tmo_d     = tmo_q;
    case (state_q)
      IDLE: if (pop) begin
        tx_data_d = mem_q[rd_ptr_q];
        tx_en_d   = 1'b1;
        state_d   = SEND;
      end
      SEND: begin
        tmo_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy)                              state_d = WAIT_DONE;
        else if (tmo_q == TMO_W'(BUSY_TMO - 1))   state_d = IDLE;
        else                                      tmo_d   = tmo_q + 1'b1;
      end
      WAIT_DONE: if (!tx_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + ADDR_W'(push);
    rd_ptr_d = rd_ptr_q + ADDR_W'(pop);
    cnt_d    = cnt_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
    ovf_d    = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
      tmo_q     <= tmo_d;
    end
  end

  // Storage carries no reset; contents are qualified by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rx_data;
  end

  assign tx_en    = tx_en_q;
  assign tx_data  = tx_data_q;
  assign fifo_cnt = cnt_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_uart_loop_buffer.sv
// Randomised and directed bench for uart_loop_buffer; a queue-based byte model
// scores every tx_en pulse, occupancy and the sticky overflow flag.
module tb_uart_loop_buffer;
  localparam int DEPTH    = 16;
  localparam int BUSY_TMO = 4;

  logic       clk = 1'b0, rst = 1'b1, rx_done = 1'b0, ovf_clr = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_busy, tx_en, ovf;
  logic [7:0] tx_data;
  logic [4:0] fifo_cnt;

  logic busy_force = 1'b0, busy_tx = 1'b0, never_busy = 1'b0;
  int   busy_len = 10;
  assign tx_busy = busy_force | busy_tx;

  uart_loop_buffer #(.DATA_W(8), .ADDR_W(4), .BUSY_TMO(BUSY_TMO)) dut (
    .clk(clk), .rst(rst), .rx_done(rx_done), .rx_data(rx_data),
    .tx_busy(tx_busy), .tx_en(tx_en), .tx_data(tx_data),
    .fifo_cnt(fifo_cnt), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  int vectors = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: bytes accepted but not yet sent, plus sticky overflow.
  logic [7:0] mq[$];
  logic       ovf_m = 1'b0;
  logic [7:0] last_tx = 8'h00;
  int         gap = 100, last_gap = 0, pops = 0, peak = 0;
  logic       s_rst, s_rx, s_busy, s_clr, drop;
  logic [7:0] s_dat, exp_b;

  initial forever begin
    @(posedge clk);
    s_rst = rst; s_rx = rx_done; s_dat = rx_data; s_busy = tx_busy; s_clr = ovf_clr;
    #1;
    if (s_rst || rst) begin
      mq.delete(); ovf_m = 1'b0; last_tx = 8'h00; gap = 100;
      check("rst_tx_en",   32'(tx_en),    32'd0);
      check("rst_cnt",     32'(fifo_cnt), 32'd0);
      check("rst_ovf",     32'(ovf),      32'd0);
      check("rst_tx_data", 32'(tx_data),  32'd0);
    end else begin
      gap++;
      drop = 1'b0;
      if (tx_en) begin
        pops++;
        if (mq.size() == 0) begin
          vectors++; errors++;
          $display("FAIL spurious_tx_en: got tx_data %0h expected no pulse", tx_data);
        end else begin
          exp_b = mq.pop_front();
          check("tx_data", 32'(tx_data), 32'(exp_b));
          last_tx = exp_b;
        end
        check("busy_at_pop", 32'(s_busy), 32'd0);
        check("pop_gap_ge4", 32'(gap >= 4), 32'd1);
        last_gap = gap;
        gap = 0;
      end else begin
        check("tx_data_hold", 32'(tx_data), 32'(last_tx));
      end
      if (s_rx) begin
        if (mq.size() < DEPTH) mq.push_back(s_dat);
        else                   drop = 1'b1;
      end
      if (s_clr) ovf_m = 1'b0;
      if (drop)  ovf_m = 1'b1;
      check("fifo_cnt", 32'(fifo_cnt), 32'(mq.size()));
      check("ovf",      32'(ovf),      32'(ovf_m));
      if (mq.size() > peak) peak = mq.size();
    end
  end

  // uart_tx stand-in: busy rises 0..2 cycles after tx_en and stays up busy_len cycles.
  initial forever begin
    int d, len;
    @(posedge clk);
    #2;
    if (tx_en && !never_busy) begin
      d   = $urandom_range(0, 2);
      len = (busy_len == 0) ? $urandom_range(2, 12) : busy_len;
      repeat (d) @(negedge clk);
      @(negedge clk) busy_tx = 1'b1;
      repeat (len) @(negedge clk);
      busy_tx = 1'b0;
    end
  end

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    rx_done = 1'b1; rx_data = d;
  endtask

  task automatic quiet(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_done = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    int  stable = 0;
    bit  done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (mq.size() == 0 && fifo_cnt == 0 && !tx_busy) stable++;
      else stable = 0;
      if (stable >= 8) done = 1'b1;
    end
    vectors++;
    if (!done) begin
      errors++;
      $display("FAIL %s_drain: got %0d bytes pending expected 0 within budget", name, mq.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected end of run");
    $fatal(1, "watchdog");
  end

  int p0;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    quiet(2);

    // 1: single byte, two-edge latency
    busy_len = 10;
    @(negedge clk); rx_done = 1'b1; rx_data = 8'hA5;
    @(posedge clk); #1;
    check("t1_cnt_after_push", 32'(fifo_cnt), 32'd1);
    check("t1_no_tx_en_yet",   32'(tx_en),    32'd0);
    @(negedge clk); rx_done = 1'b0;
    @(posedge clk); #1;
    check("t1_tx_en",   32'(tx_en),    32'd1);
    check("t1_tx_data", 32'(tx_data), 32'hA5);
    check("t1_cnt_pop", 32'(fifo_cnt), 32'd0);
    wait_drain("t1");

    // 2: burst of five while transmitter is slow
    busy_len = 20; p0 = pops; peak = 0;
    for (int i = 1; i <= 5; i++) send(8'(i));
    quiet(1);
    wait_drain("t2");
    check("t2_pops", 32'(pops - p0), 32'd5);
    check("t2_peak_ok", 32'(peak >= 4 && peak <= 5), 32'd1);
    check("t2_ovf", 32'(ovf), 32'd0);

    // 3: overflow with transmitter held busy
    busy_force = 1'b1; p0 = pops;
    quiet(2);
    for (int i = 0; i < 18; i++) send(8'(8'h10 + i));
    quiet(1);
    check("t3_cnt_full", 32'(fifo_cnt), 32'd16);
    check("t3_ovf_set",  32'(ovf),      32'd1);
    busy_force = 1'b0;
    wait_drain("t3");
    check("t3_pops", 32'(pops - p0), 32'd16);
    check("t3_last", 32'(last_tx), 32'h1F);
    @(negedge clk) ovf_clr = 1'b1;
    @(negedge clk) ovf_clr = 1'b0;
    check("t3_ovf_clr", 32'(ovf), 32'd0);

    // 4: busy never rises, timeout returns to IDLE
    never_busy = 1'b1; p0 = pops;
    send(8'h3C); send(8'hC3);
    quiet(1);
    wait_drain("t4");
    check("t4_pops", 32'(pops - p0), 32'd2);
    check("t4_gap",  32'(last_gap), 32'(BUSY_TMO + 2));
    check("t4_last", 32'(last_tx), 32'hC3);
    never_busy = 1'b0;

    // 5: full FIFO with simultaneous pop and push
    busy_len = 3; busy_force = 1'b1;
    quiet(2);
    for (int i = 0; i < 16; i++) send(8'(8'h80 + i));
    quiet(1);
    check("t5_cnt_full", 32'(fifo_cnt), 32'd16);
    @(negedge clk); busy_force = 1'b0; rx_done = 1'b1; rx_data = 8'hEE;
    @(negedge clk); rx_done = 1'b0;
    check("t5_cnt_stays", 32'(fifo_cnt), 32'd16);
    check("t5_ovf_clear", 32'(ovf), 32'd0);
    wait_drain("t5");
    check("t5_last_new", 32'(last_tx), 32'hEE);

    // 6: reset while waiting for the transmitter to finish
    busy_len = 40;
    for (int i = 0; i < 4; i++) send(8'(8'h61 + i));
    quiet(8);
    check("t6_queued", 32'(fifo_cnt), 32'd3);
    rst = 1'b1;
    #1;
    check("t6_rst_tx_en", 32'(tx_en),    32'd0);
    check("t6_rst_cnt",   32'(fifo_cnt), 32'd0);
    check("t6_rst_ovf",   32'(ovf),      32'd0);
    @(negedge clk) rst = 1'b0;
    send(8'h77);
    quiet(1);
    wait_drain("t6");
    check("t6_after_rst", 32'(last_tx), 32'h77);

    // random traffic with variable transmitter timing
    busy_len = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      rx_done = ($urandom_range(0, 99) < 30);
      rx_data = 8'($urandom);
      ovf_clr = ($urandom_range(0, 99) < 3);
    end
    @(negedge clk); rx_done = 1'b0; ovf_clr = 1'b0;
    wait_drain("rand");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
